adxl362_spi_responder: RTL and testbench
========================================

# adxl362_spi_responder

SPI mode-0 responder that models the ADXL362 register interface for the X/Y acquisition path. It lets the Shot Simulator's SPI master be exercised in closed loop, in simulation and on-board loopback, without the physical accelerometer. It decodes the write (0x0A) and read (0x0B) commands with address auto-increment and holds a small register file. X/Y sample words come from ports and are frozen per transaction.

## Interface

Parameters:
- SYNC_STAGES, 2: synchronizer depth on sclk/cs/mosi; legal range 1..3.
- DEVID_AD, 8'hAD: value returned at address 0x00.
- DEVID_MST, 8'h1D: value returned at address 0x01.
- PARTID, 8'hF2: value returned at address 0x02.

Ports:
- iclk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master; idles low.
- cs  in  1  chip select, active low.
- mosi  in  1  master-out data, MSB first.
- miso  out  1  responder-out data.
- x_sample  in  16  X word; reads as X_L=[7:0], X_H=[15:8].
- y_sample  in  16  Y word; reads as Y_L=[7:0], Y_H=[15:8].
- power_ctl  out  8  POWER_CTL register (0x2D).
- measure_on  out  1  high when power_ctl[1:0]==2'b10.
- wr_strobe  out  1  1-cycle pulse per completed write data byte.
- wr_addr  out  6  address of the byte that raised wr_strobe.
- wr_data  out  8  data of the byte that raised wr_strobe.

## Operation

- sclk, cs and mosi each pass through SYNC_STAGES flops. Edge detect compares the last synchronized stage with one further register.
- Only the synchronized signals are used inside the block.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
- IDLE: cs high. A synchronized cs falling edge clears the bit counter, snapshots x_sample/y_sample into x_snap/y_snap, and moves to CMD.
- On each synchronized sclk rise: rx shift register takes mosi and the bit counter increments. On the 8th bit the byte completes.
- CMD on byte complete:
  - 0x0A → ADDR, then WDATA.
  - 0x0B → ADDR, then RDATA.
  - any other value → IGNORE.
- ADDR on byte complete: addr ← byte[5:0]; byte[7:6] are ignored. In read mode, load the tx shifter with reg(addr).
- WDATA on byte complete:
  - Pulse wr_strobe with wr_addr=addr and wr_data=byte.
  - If addr==0x2D, update power_ctl. Writes to any other address are discarded.
  - addr ← addr+1.
- RDATA on byte complete: addr ← addr+1, then load the tx shifter with reg(new addr).
- Address auto-increment wraps 0x3F → 0x00.
- Read map:
  - 0x00/0x01/0x02 return the ID parameters.
  - 0x0E/0x0F return x_snap low/high byte.
  - 0x10/0x11 return y_snap low/high byte.
  - 0x2D returns power_ctl.
  - All other addresses return 0x00.
  - X/Y addresses return 0x00 while measure_on is low.
- IGNORE: drive miso=0 until cs rises.
- A synchronized cs rise in any state returns the FSM to IDLE:
  - a partial byte is discarded;
  - no wr_strobe fires;
  - addr does not increment.
- sclk edges while cs is high are ignored.
- Snapshot coherency: x_snap/y_snap load only on a cs falling edge. Input changes mid-transaction are not visible until the next transaction.

## Timing

- Reset values: miso=0, power_ctl=8'h00, measure_on=0, wr_strobe=0, wr_addr=0, wr_data=0. FSM in IDLE; all synchronizers and snapshots are 0.
- Reset asserted mid-transaction aborts the transaction immediately. After release, the responder waits for a fresh cs fall.
- miso is registered:
  - It changes one iclk after a detected sclk rise, presenting the next bit.
  - The MSB of each read byte appears one iclk after the rise that completes the preceding byte, so it is valid before the next rise.
  - miso is 0 in IDLE, CMD, ADDR, WDATA and IGNORE.
- Latency from a pin edge to internal detection is SYNC_STAGES+1 iclk cycles.
- Guaranteed operation requires an SCLK high or low time ≥ SYNC_STAGES+2 iclk. With SYNC_STAGES=2 that means SCLK ≤ iclk/8.
- wr_strobe asserts SYNC_STAGES+2 iclk after the 8th sclk rise of a write data byte. It is exactly one cycle wide. power_ctl and measure_on update in that same cycle.
- Simultaneous cs rise and 8th-bit rise in the same synchronized cycle: cs wins and the byte is discarded.

## Test plan

- Reset, then read 0x0B/0x00 over 3 bytes → miso returns 0xAD, 0x1D, 0xF2. power_ctl=0x00.
- Write 0x0A/0x2D/0x02 → one wr_strobe with wr_addr=0x2D, wr_data=0x02. power_ctl=0x02 and measure_on=1. A subsequent read of 0x2D returns 0x02.
- With measure_on=1, x_sample=16'h0ABC, y_sample=16'hF123: read 0x0B/0x0E over 4 bytes → 0xBC, 0x0A, 0x23, 0xF1. Changing the inputs mid-burst does not alter the returned bytes. With measure_on=0 the same read returns four 0x00 bytes.
- Read starting at 0x3F over 2 bytes → 0x00, then DEVID_AD (0xAD) after the wrap.
- Write 0x0A/0x2D then raise cs after 5 bits of the data byte → no wr_strobe and power_ctl unchanged. Command 0x55 → miso stays 0 for the whole frame and no strobe fires.
- Closed loop with the team SPI master at iclk/8 and x/y driven constant → master reports matching x_raw/y_raw after its power-up write; rst_n pulsed mid-burst → the responder recovers on the next frame.

Source files
------------

// File: rtl/adxl362_spi_responder.sv
// adxl362_spi_responder
// SPI mode-0 responder that mimics the ADXL362 register interface for the X/Y
// acquisition path, so the SPI master can run in closed loop without the part.
// All SPI pins are oversampled on iclk; only synchronized copies are used.
module adxl362_spi_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_AD    = 8'hAD,
    parameter logic [7:0]  DEVID_MST   = 8'h1D,
    parameter logic [7:0]  PARTID      = 8'hF2
) (
    input  logic        iclk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    input  logic [15:0] x_sample,
    input  logic [15:0] y_sample,
    output logic [7:0]  power_ctl,
    output logic        measure_on,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

    localparam logic [5:0] POWER_CTL_ADDR = 6'h2D;

    // {sclk, cs, mosi} per synchronizer stage; stage SYNC_STAGES-1 is the usable copy
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, cs_rise, cs_fall;

    state_t      state;
    logic        rd_mode;
    logic [2:0]  bitcnt;
    logic [6:0]  rx;
    logic [6:0]  tx;
    logic [5:0]  addr;
    logic [15:0] x_snap, y_snap;
    logic [7:0]  byte_in;

    assign sclk_s    = sync_q[SYNC_STAGES-1][2];
    assign cs_s      = sync_q[SYNC_STAGES-1][1];
    assign mosi_s    = sync_q[SYNC_STAGES-1][0];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign byte_in   = {rx, mosi_s};
    assign measure_on = (power_ctl[1:0] == 2'b10);

    // Register read map; sample bytes are hidden until measurement mode is on
    function automatic logic [7:0] read_map(input logic [5:0] a);
        logic [7:0] d;
        d = 8'h00;
        case (a)
            6'h00: d = DEVID_AD;
            6'h01: d = DEVID_MST;
            6'h02: d = PARTID;
            6'h0E: d = measure_on ? x_snap[7:0]  : 8'h00;
            6'h0F: d = measure_on ? x_snap[15:8] : 8'h00;
            6'h10: d = measure_on ? y_snap[7:0]  : 8'h00;
            6'h11: d = measure_on ? y_snap[15:8] : 8'h00;
            6'h2D: d = power_ctl;
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    // Pin synchronizers plus one extra stage on sclk/cs for edge detection
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sync_q[0] <= {sclk, cs, mosi};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    // Protocol FSM: cs rise aborts anything in flight (partial byte dropped,
    // no strobe, no address step) and takes priority over a completing bit
    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_mode   <= 1'b0;
            bitcnt    <= 3'd0;
            rx        <= 7'd0;
            tx        <= 7'd0;
            addr      <= 6'd0;
            x_snap    <= 16'd0;
            y_snap    <= 16'd0;
            miso      <= 1'b0;
            power_ctl <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr   <= 6'd0;
            wr_data   <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (cs_rise) begin
                state <= IDLE;
                miso  <= 1'b0;
            end else if (state == IDLE) begin
                miso <= 1'b0;
                if (cs_fall) begin
                    bitcnt  <= 3'd0;
                    rd_mode <= 1'b0;
                    x_snap  <= x_sample;
                    y_snap  <= y_sample;
                    state   <= CMD;
                end
            end else if (sclk_rise) begin
                rx     <= byte_in[6:0];
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    case (state)
                        CMD: begin
                            if (byte_in == 8'h0A) begin
                                rd_mode <= 1'b0;
                                state   <= ADDR;
                            end else if (byte_in == 8'h0B) begin
                                rd_mode <= 1'b1;
                                state   <= ADDR;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                        ADDR: begin
                            addr <= byte_in[5:0];
                            if (rd_mode) begin
                                {miso, tx} <= read_map(byte_in[5:0]);
                                state      <= RDATA;
                            end else begin
                                state <= WDATA;
                            end
                        end
                        WDATA: begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                            wr_data   <= byte_in;
                            if (addr == POWER_CTL_ADDR) power_ctl <= byte_in;
                            addr <= addr + 6'd1;
                        end
                        RDATA: begin
                            addr       <= addr + 6'd1;
                            {miso, tx} <= read_map(addr + 6'd1);
                        end
                        default: ;
                    endcase
                end else if (state == RDATA) begin
                    miso <= tx[6];
                    tx   <= {tx[5:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for adxl362_spi_responder: drives SPI mode-0 frames at
// iclk/16 per bit and checks read data, write strobes and register effects.
module tb_adxl362_spi_responder;

    logic        iclk, rst_n, sclk, cs, mosi, miso;
    logic [15:0] x_sample, y_sample;
    logic [7:0]  power_ctl;
    logic        measure_on, wr_strobe;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    logic [5:0] s_addr [8];
    logic [7:0] s_data [8];

    logic [7:0]  b0, b1, b2, b3, dummy;

    adxl362_spi_responder dut (
        .iclk(iclk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .x_sample(x_sample), .y_sample(y_sample), .power_ctl(power_ctl),
        .measure_on(measure_on), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Log every cycle wr_strobe is high; a stretched pulse shows up as extra entries
    always @(negedge iclk) begin
        if (wr_strobe === 1'b1) begin
            s_addr[strobe_cnt % 8] = wr_addr;
            s_data[strobe_cnt % 8] = wr_data;
            strobe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge iclk);
    endtask

    task automatic bits(input logic [7:0] t, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = t[i];
            half();
            r[i] = miso;
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] t, output logic [7:0] r);
        bits(t, 8, r);
    endtask

    task automatic frame_start();
        cs = 1'b0;
        half();
    endtask

    task automatic frame_end();
        half();
        cs = 1'b1;
        mosi = 1'b0;
        half();
        half();
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        x_sample = 16'h0000; y_sample = 16'h0000;
        repeat (4) @(negedge iclk);
        rst_n = 1'b1;
        repeat (6) @(negedge iclk);

        // reset state
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_power_ctl", {24'd0, power_ctl}, 32'h00);
        check("rst_measure_on", {31'd0, measure_on}, 32'd0);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);

        // ID read burst
        frame_start();
        xfer(8'h0B, dummy); xfer(8'h00, dummy);
        xfer(8'h00, b0); xfer(8'h00, b1); xfer(8'h00, b2);
        frame_end();
        check("id_read", {8'd0, b0, b1, b2}, 32'h00AD1DF2);
        check("id_power_ctl", {24'd0, power_ctl}, 32'h00);

        // Two-byte write burst at 0x2C with auto-increment into POWER_CTL
        frame_start();
        xfer(8'h0A, dummy); xfer(8'h2C, dummy); xfer(8'h11, dummy); xfer(8'h02, dummy);
        frame_end();
        check("wr_strobe_count", strobe_cnt, 32'd2);
        check("wr_first", {18'd0, s_addr[0], s_data[0]}, {18'd0, 6'h2C, 8'h11});
        check("wr_second", {18'd0, s_addr[1], s_data[1]}, {18'd0, 6'h2D, 8'h02});
        check("wr_out_hold", {18'd0, wr_addr, wr_data}, {18'd0, 6'h2D, 8'h02});
        check("wr_power_ctl", {24'd0, power_ctl}, 32'h02);
        check("wr_measure_on", {31'd0, measure_on}, 32'd1);
        check("rd_miso_idle", {31'd0, miso}, 32'd0);

        frame_start();
        xfer(8'h0B, dummy); xfer(8'h2D, dummy); xfer(8'h00, b0);
        frame_end();
        check("rd_power_ctl", {24'd0, b0}, 32'h02);

        // X/Y burst; inputs change mid-burst and must not leak in
        x_sample = 16'h0ABC; y_sample = 16'hF123;
        frame_start();
        xfer(8'h0B, dummy); xfer(8'h0E, dummy);
        xfer(8'h00, b0);
        x_sample = 16'h5555; y_sample = 16'h6666;
        xfer(8'h00, b1); xfer(8'h00, b2); xfer(8'h00, b3);
        frame_end();
        check("xy_read", {b0, b1, b2, b3}, 32'hBC0A23F1);

        // Standby: sample registers read as zero
        x_sample = 16'h0ABC; y_sample = 16'hF123;
        frame_start();
        xfer(8'h0A, dummy); xfer(8'h2D, dummy); xfer(8'h00, dummy);
        frame_end();
        check("standby_measure_on", {31'd0, measure_on}, 32'd0);
        frame_start();
        xfer(8'h0B, dummy); xfer(8'h0E, dummy);
        xfer(8'h00, b0); xfer(8'h00, b1); xfer(8'h00, b2); xfer(8'h00, b3);
        frame_end();
        check("xy_read_standby", {b0, b1, b2, b3}, 32'h00000000);

        // Address wrap 0x3F -> 0x00
        frame_start();
        xfer(8'h0B, dummy); xfer(8'h3F, dummy); xfer(8'h00, b0); xfer(8'h00, b1);
        frame_end();
        check("wrap_read", {16'd0, b0, b1}, 32'h000000AD);

        // Partial data byte: cs rises after 5 bits
        frame_start();
        xfer(8'h0A, dummy); xfer(8'h2D, dummy); bits(8'hFF, 5, dummy);
        frame_end();
        check("partial_strobe_count", strobe_cnt, 32'd3);
        check("partial_power_ctl", {24'd0, power_ctl}, 32'h00);

        // Unknown command: miso held low all frame
        frame_start();
        xfer(8'h55, b0); xfer(8'h2D, b1); xfer(8'hFF, b2);
        frame_end();
        check("ignore_miso", {8'd0, b0, b1, b2}, 32'd0);
        check("ignore_strobe_count", strobe_cnt, 32'd3);

        // Reset mid-burst, then recover on a fresh frame
        frame_start();
        xfer(8'h0A, dummy); xfer(8'h2D, dummy); xfer(8'h02, dummy);
        frame_end();
        check("pre_rst_power_ctl", {24'd0, power_ctl}, 32'h02);
        frame_start();
        xfer(8'h0B, dummy); xfer(8'h00, dummy); xfer(8'h00, dummy);
        bits(8'h00, 3, dummy);
        rst_n = 1'b0;
        repeat (3) @(negedge iclk);
        check("midrst_power_ctl", {24'd0, power_ctl}, 32'h00);
        check("midrst_miso", {31'd0, miso}, 32'd0);
        rst_n = 1'b1;
        xfer(8'h00, b0); xfer(8'h00, b1);
        frame_end();
        check("post_rst_stale_frame", {16'd0, b0, b1}, 32'd0);
        frame_start();
        xfer(8'h0B, dummy); xfer(8'h00, dummy); xfer(8'h00, b0); xfer(8'h00, b1);
        frame_end();
        check("post_rst_read", {16'd0, b0, b1}, 32'h0000AD1D);
        check("post_rst_strobe_count", strobe_cnt, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
